pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the five-stage RISC-V pipeline.
- Drives hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazards with a small FSM: load-use, taken branch/jump, and multi-cycle DRAM access.
- Sits beside the pipeline registers. Takes hazard info from ID, EX and MEM; its outputs gate the register enables and clears.

---
 rtl/pipe_hazard_ctrl_if.sv | 46 ++++
 rtl/pipe_hazard_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard information from the ID/EX/MEM stages and the hold/clear controls
// returned to the pipeline registers. The pipeline side is the master.
interface pipe_hazard_ctrl_if #(
    parameter int WIDTH_REGMARK = 5
);
    logic [WIDTH_REGMARK-1:0] id_rs1;
    logic [WIDTH_REGMARK-1:0] id_rs2;
    logic                     id_rs1_used;
    logic                     id_rs2_used;
    logic [WIDTH_REGMARK-1:0] ex_RegWr;
    logic                     ex_RegWe;
    logic                     ex_is_load;
    logic                     ex_branch_taken;
    logic                     mem_req;
    logic                     mem_ack;

    logic                     pc_stall;
    logic                     ifid_stall;
    logic                     ifid_flush;
    logic                     idex_stall;
    logic                     idex_flush;
    logic                     exmem_stall;
    logic                     memwb_flush;
    logic [1:0]               hz_state;
    logic                     mem_err;
    logic [31:0]              stall_cycles;
    logic [31:0]              flush_count;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_RegWr, ex_RegWe, ex_is_load, ex_branch_taken,
               mem_req, mem_ack,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, hz_state, mem_err,
               stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               ex_RegWr, ex_RegWe, ex_is_load, ex_branch_taken,
               mem_req, mem_ack,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
               exmem_stall, memwb_flush, hz_state, mem_err,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, taken branch
// and DRAM wait hazards. Define HAZARD_PERF_EN to build the perf counters.
module pipe_hazard_ctrl #(
    parameter int WIDTH_REGMARK = 5,
    parameter int MEM_TIMEOUT   = 15,
    parameter int WIDTH_WCNT    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH_WCNT-1:0] wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;

    logic ldu, mwait, timeout;
    logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
    logic idex_flush_c, exmem_stall_c, memwb_flush_c;

    assign ldu = hz.ex_is_load & hz.ex_RegWe & (hz.ex_RegWr != '0) &
                 ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_RegWr)) |
                  (hz.id_rs2_used & (hz.id_rs2 == hz.ex_RegWr)));
    assign mwait   = hz.mem_req & ~hz.mem_ack;
    assign timeout = (state_q == ST_MEMWAIT) &
                     (wait_cnt_q == WIDTH_WCNT'(MEM_TIMEOUT)) & ~hz.mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = ST_RUN;
        wait_cnt_d    = '0;
        err_d         = err_q;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_stall_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_stall_c = 1'b0;
        memwb_flush_c = 1'b0;
        if (timeout) begin
            // Abort the DRAM wait: release everything and return to RUN.
            err_d = 1'b1;
        end else if (mwait) begin
            pc_stall_c    = 1'b1;
            ifid_stall_c  = 1'b1;
            idex_stall_c  = 1'b1;
            exmem_stall_c = 1'b1;
            memwb_flush_c = 1'b1;
            state_d       = ST_MEMWAIT;
            wait_cnt_d    = (state_q == ST_MEMWAIT) ? wait_cnt_q + 1'b1 : '0;
        end else if (hz.ex_branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = ST_FLUSH;
        end else if (ldu && (state_q == ST_RUN || state_q == ST_FLUSH)) begin
            // LDUSE already put a bubble in EX, so a stalled ldu cannot re-fire.
            pc_stall_c   = 1'b1;
            ifid_stall_c = 1'b1;
            idex_flush_c = 1'b1;
            state_d      = ST_LDUSE;
        end
    end

    assign hz.pc_stall    = pc_stall_c    & rst_n;
    assign hz.ifid_stall  = ifid_stall_c  & rst_n;
    assign hz.ifid_flush  = ifid_flush_c  & rst_n;
    assign hz.idex_stall  = idex_stall_c  & rst_n;
    assign hz.idex_flush  = idex_flush_c  & rst_n;
    assign hz.exmem_stall = exmem_stall_c & rst_n;
    assign hz.memwb_flush = memwb_flush_c & rst_n;
    assign hz.hz_state    = state_q;
    assign hz.mem_err     = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'd0, pc_stall_c};
            flush_count_q  <= flush_count_q + {31'd0, ifid_flush_c};
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`else
    assign hz.stall_cycles = 32'd0;
    assign hz.flush_count  = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level
// reference model built from the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int WR   = 5;
    localparam int TMO  = 15;
    localparam int WCNT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.WIDTH_REGMARK(WR)) hif ();

    pipe_hazard_ctrl #(.WIDTH_REGMARK(WR), .MEM_TIMEOUT(TMO), .WIDTH_WCNT(WCNT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the pipeline is currently doing, not how.
    bit          m_in_wait, m_last_ldu, m_last_flush, m_err;
    int          m_waited;      // consecutive DRAM stall cycles so far
    logic [31:0] m_stall_cnt, m_flush_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {hif.pc_stall, hif.ifid_stall, hif.ifid_flush, hif.idex_stall,
                hif.idex_flush, hif.exmem_stall, hif.memwb_flush};
    endfunction

    task automatic model_clear();
        m_in_wait = 0; m_last_ldu = 0; m_last_flush = 0; m_err = 0;
        m_waited = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    task automatic idle();
        hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_rs1_used = 0; hif.id_rs2_used = 0;
        hif.ex_RegWr = '0; hif.ex_RegWe = 0; hif.ex_is_load = 0;
        hif.ex_branch_taken = 0; hif.mem_req = 0; hif.mem_ack = 0;
    endtask

    task automatic set_ldu(input logic [WR-1:0] rd, input logic [WR-1:0] rs1);
        idle();
        hif.ex_is_load = 1; hif.ex_RegWe = 1; hif.ex_RegWr = rd;
        hif.id_rs1 = rs1; hif.id_rs1_used = 1;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic step();
        logic [6:0] e_ctrl;
        logic [1:0] e_hz;
        bit mwait, ldu, tmo, n_wait, n_ldu, n_flush;
        int n_waited;
        #1;
        mwait = hif.mem_req && !hif.mem_ack;
        ldu = hif.ex_is_load && hif.ex_RegWe && (hif.ex_RegWr != 0) &&
              ((hif.id_rs1_used && hif.id_rs1 == hif.ex_RegWr) ||
               (hif.id_rs2_used && hif.id_rs2 == hif.ex_RegWr));
        tmo = m_in_wait && (m_waited > TMO) && !hif.mem_ack;
        e_hz = m_in_wait ? 2'd2 : m_last_ldu ? 2'd1 : m_last_flush ? 2'd3 : 2'd0;
        e_ctrl = '0; n_wait = 0; n_ldu = 0; n_flush = 0; n_waited = 0;
        if (tmo) begin
            // all released
        end else if (mwait) begin
            e_ctrl = 7'b1101011;
            n_wait = 1;
            n_waited = m_in_wait ? m_waited + 1 : 1;
        end else if (hif.ex_branch_taken) begin
            e_ctrl = 7'b0010100;
            n_flush = 1;
        end else if (ldu && !m_last_ldu && !m_in_wait) begin
            e_ctrl = 7'b1100100;
            n_ldu = 1;
        end
        check("ctrl", {25'd0, ctrl_vec()}, {25'd0, e_ctrl});
        check("hz_state", {30'd0, hif.hz_state}, {30'd0, e_hz});
        check("mem_err", {31'd0, hif.mem_err}, {31'd0, m_err});
        check("stall_cycles", hif.stall_cycles, m_stall_cnt);
        check("flush_count", hif.flush_count, m_flush_cnt);
        @(posedge clk);
        m_in_wait = n_wait; m_last_ldu = n_ldu; m_last_flush = n_flush;
        m_waited = n_waited;
        if (tmo) m_err = 1;
`ifdef HAZARD_PERF_EN
        m_stall_cnt = m_stall_cnt + e_ctrl[6];
        m_flush_cnt = m_flush_cnt + e_ctrl[4];
`endif
        @(negedge clk);
    endtask

    // Asserts reset immediately (asynchronously) and releases it at a falling edge.
    task automatic apply_reset();
        rst_n = 0;
        #1;
        check("rst_ctrl", {25'd0, ctrl_vec()}, 32'd0);
        check("rst_hz_state", {30'd0, hif.hz_state}, 32'd0);
        check("rst_mem_err", {31'd0, hif.mem_err}, 32'd0);
        check("rst_stall_cycles", hif.stall_cycles, 32'd0);
        check("rst_flush_count", hif.flush_count, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        model_clear();
        idle();
        @(negedge clk);
        apply_reset();

        // Load-use: one stall cycle, then LDUSE, then RUN.
        set_ldu(5'd5, 5'd5); step(); step();
        idle(); step();
        // x0 never hazards.
        set_ldu(5'd0, 5'd0); step(); step();
        // Branch and load-use together: branch wins.
        set_ldu(5'd5, 5'd5); hif.ex_branch_taken = 1; step();
        idle(); step();
        // DRAM wait of 3 cycles with a branch held, flushed on the ack cycle.
        idle(); hif.mem_req = 1; hif.ex_branch_taken = 1;
        repeat (3) step();
        hif.mem_ack = 1; step();
        idle(); step(); step();
        // Timeout: 16 stall cycles, then abort and sticky error.
        hif.mem_req = 1;
        repeat (17) step();
        idle(); step(); step();
        check("mem_err_sticky", {31'd0, hif.mem_err}, 32'd1);
        // Second wait, reset mid-wait.
        hif.mem_req = 1;
        repeat (3) step();
        #2;
        apply_reset();
        idle();
        step();

        // Perf scenario: 2 load-use stalls, 3 DRAM-wait cycles, 1 branch.
        apply_reset();
        set_ldu(5'd7, 5'd7); step(); idle(); step();
        set_ldu(5'd3, 5'd3); step(); idle(); step();
        hif.mem_req = 1; repeat (3) step();
        hif.mem_ack = 1; step();
        idle(); hif.ex_branch_taken = 1; step();
        idle(); step();
`ifdef HAZARD_PERF_EN
        check("perf_stall_total", hif.stall_cycles, 32'd5);
        check("perf_flush_total", hif.flush_count, 32'd1);
`else
        check("perf_stall_off", hif.stall_cycles, 32'd0);
        check("perf_flush_off", hif.flush_count, 32'd0);
`endif

        // Randomized traffic with small register indices to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            hif.id_rs1      = WR'($urandom_range(0, 3));
            hif.id_rs2      = WR'($urandom_range(0, 3));
            hif.id_rs1_used = $urandom_range(0, 1);
            hif.id_rs2_used = $urandom_range(0, 1);
            hif.ex_RegWr    = WR'($urandom_range(0, 3));
            hif.ex_RegWe    = ($urandom_range(0, 3) != 0);
            hif.ex_is_load  = $urandom_range(0, 1);
            hif.ex_branch_taken = ($urandom_range(0, 6) == 0);
            hif.mem_req     = ($urandom_range(0, 4) == 0) || (m_in_wait && $urandom_range(0, 3) != 0);
            hif.mem_ack     = hif.mem_req && ($urandom_range(0, 2) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
